// File: rtl/d_to_t_ff.sv
// Bank of WIDTH independent T flip-flops, each a D register fed by D = T ^ Q.
// Optional clock enable port when D_TO_T_FF_CE_EN is defined.
module d_to_t_ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef D_TO_T_FF_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q
);

    logic             w_ce;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] r_q;

`ifdef D_TO_T_FF_CE_EN
    assign w_ce = ce;
`else
    assign w_ce = 1'b1;
`endif

    // Enable gates the toggle request, so a disabled cell sees D = 0 ^ Q and holds.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_t[gi] = T[gi] & w_ce;
            assign w_d[gi] = w_t[gi] ^ r_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= w_d;
        end
    end

    assign Q = r_q;

endmodule

// File: tb/tb_d_to_t_ff.sv
// Randomised and directed checks of d_to_t_ff against a toggle-count model.
module tb_d_to_t_ff;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       T1;
    logic [3:0] T4;
    logic       Q1;
    logic [3:0] Q4;
    logic [3:0] Q4b;

    localparam logic [3:0] RV_B = 4'b0110;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: number of toggles since the last reset, per bit.
    int cnt1;
    int cnt4[4];

    always #5 clk = ~clk;

    d_to_t_ff #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset),
`ifdef D_TO_T_FF_CE_EN
        .ce(ce),
`endif
        .T(T1), .Q(Q1)
    );

    d_to_t_ff #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
`ifdef D_TO_T_FF_CE_EN
        .ce(ce),
`endif
        .T(T4), .Q(Q4)
    );

    d_to_t_ff #(.WIDTH(4), .RESET_VALUE(RV_B)) dut4b (
        .clk(clk), .reset(reset),
`ifdef D_TO_T_FF_CE_EN
        .ce(ce),
`endif
        .T(T4), .Q(Q4b)
    );

    function automatic logic exp1();
        return (cnt1 % 2) == 1;
    endfunction

    function automatic logic [3:0] exp4(input logic [3:0] rv);
        logic [3:0] e;
        for (int b = 0; b < 4; b++) e[b] = rv[b] ^ ((cnt4[b] % 2) == 1);
        return e;
    endfunction

    // Drive one cycle of inputs, clock once, update model; checks live in callers.
    task automatic step(input logic rst, input logic t1, input logic [3:0] t4, input logic c);
        logic ce_eff;
        reset = rst; T1 = t1; T4 = t4; ce = c;
`ifdef D_TO_T_FF_CE_EN
        ce_eff = c;
`else
        ce_eff = 1'b1;
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            cnt1 = 0;
            for (int b = 0; b < 4; b++) cnt4[b] = 0;
        end else if (ce_eff) begin
            cnt1 += int'(t1);
            for (int b = 0; b < 4; b++) cnt4[b] += int'(t4[b]);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        n_cmp++;
        if (Q1 !== 1'b0) begin n_bad++; $display("FAIL reset_q1: got %b want 0", Q1); end
        n_cmp++;
        if (Q4 !== 4'b0000) begin n_bad++; $display("FAIL reset_q4: got %b want 0000", Q4); end
        n_cmp++;
        if (Q4b !== RV_B) begin n_bad++; $display("FAIL reset_q4b: got %b want %b", Q4b, RV_B); end
        $display("test_reset: Q1=%b Q4=%b Q4b=%b", Q1, Q4, Q4b);
    endtask

    task automatic test_hold_zero();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 4'b0000, 1'b1);
            n_cmp++;
            if (Q1 !== 1'b0) begin n_bad++; $display("FAIL hold_zero[%0d]: got %b want 0", i, Q1); end
            $display("test_hold_zero[%0d]: Q1=%b", i, Q1);
        end
    endtask

    task automatic test_double_toggle();
        logic want[3] = '{1'b1, 1'b0, 1'b0};
        logic tin[3]  = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, tin[i], 4'b0000, 1'b1);
            n_cmp++;
            if (Q1 !== want[i]) begin n_bad++; $display("FAIL double_toggle[%0d]: got %b want %b", i, Q1, want[i]); end
            $display("test_double_toggle[%0d]: T=%b Q1=%b", i, tin[i], Q1);
        end
    endtask

    task automatic test_toggle_hold();
        logic tin[3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, tin[i], 4'b0000, 1'b1);
            n_cmp++;
            if (Q1 !== 1'b1) begin n_bad++; $display("FAIL toggle_hold[%0d]: got %b want 1", i, Q1); end
            $display("test_toggle_hold[%0d]: T=%b Q1=%b", i, tin[i], Q1);
        end
    endtask

    task automatic test_reset_mid();
        // Q1 is 1 here; raising reset must not act before the edge.
        reset = 1'b1; T1 = 1'b1;
        #1;
        n_cmp++;
        if (Q1 !== 1'b1) begin n_bad++; $display("FAIL reset_not_async: got %b want 1", Q1); end
        step(1'b1, 1'b1, 4'b1111, 1'b1);
        n_cmp++;
        if (Q1 !== 1'b0) begin n_bad++; $display("FAIL reset_mid: got %b want 0", Q1); end
        step(1'b0, 1'b1, 4'b0000, 1'b1);
        n_cmp++;
        if (Q1 !== 1'b1) begin n_bad++; $display("FAIL reset_resume: got %b want 1", Q1); end
        $display("test_reset_mid: Q1=%b", Q1);
    endtask

    task automatic test_width4();
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b0, 4'b1010, 1'b1);
        n_cmp++;
        if (Q4 !== 4'b1010) begin n_bad++; $display("FAIL width4_a: got %b want 1010", Q4); end
        n_cmp++;
        if (Q4b !== 4'b1100) begin n_bad++; $display("FAIL width4b_a: got %b want 1100", Q4b); end
        step(1'b0, 1'b0, 4'b1010, 1'b1);
        n_cmp++;
        if (Q4 !== 4'b0000) begin n_bad++; $display("FAIL width4_b: got %b want 0000", Q4); end
        n_cmp++;
        if (Q4b !== RV_B) begin n_bad++; $display("FAIL width4b_b: got %b want %b", Q4b, RV_B); end
        $display("test_width4: Q4=%b Q4b=%b", Q4, Q4b);
    endtask

`ifdef D_TO_T_FF_CE_EN
    task automatic test_ce();
        step(1'b0, 1'b1, 4'b0101, 1'b1);
        step(1'b0, 1'b1, 4'b1111, 1'b0);
        n_cmp++;
        if (Q4 !== 4'b0101) begin n_bad++; $display("FAIL ce_hold: got %b want 0101", Q4); end
        step(1'b1, 1'b1, 4'b1111, 1'b0);
        n_cmp++;
        if (Q4 !== 4'b0000) begin n_bad++; $display("FAIL ce_reset: got %b want 0000", Q4); end
        $display("test_ce: Q4=%b", Q4);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic       r;
            logic       t1;
            logic [3:0] t4;
            logic       c;
            r  = ($urandom_range(0, 15) == 0);
            t1 = 1'($urandom);
            t4 = 4'($urandom);
            c  = ($urandom_range(0, 3) != 0);
            step(r, t1, t4, c);
            n_cmp++;
            if (Q1 !== exp1()) begin n_bad++; $display("FAIL rand_q1[%0d]: got %b want %b", i, Q1, exp1()); end
            n_cmp++;
            if (Q4 !== exp4(4'b0000)) begin n_bad++; $display("FAIL rand_q4[%0d]: got %b want %b", i, Q4, exp4(4'b0000)); end
            n_cmp++;
            if (Q4b !== exp4(RV_B)) begin n_bad++; $display("FAIL rand_q4b[%0d]: got %b want %b", i, Q4b, exp4(RV_B)); end
            $display("test_random[%0d]: r=%b ce=%b T1=%b T4=%b Q1=%b Q4=%b Q4b=%b", i, r, c, t1, t4, Q1, Q4, Q4b);
        end
    endtask

    initial begin
        reset = 1'b0; ce = 1'b1; T1 = 1'b0; T4 = 4'b0000;
        cnt1 = 0;
        for (int b = 0; b < 4; b++) cnt4[b] = 0;
        @(negedge clk);
        test_reset();
        test_hold_zero();
        test_double_toggle();
        test_toggle_hold();
        test_reset_mid();
        test_width4();
`ifdef D_TO_T_FF_CE_EN
        test_ce();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
